// File: rtl/sample_sched_pkg.sv
// Shared constants and types for the round-robin sample scheduler.
// Sample word layout: {cnt[15:0], marker[14:0], sample bit}.
package sample_sched_pkg;

    localparam logic [14:0] SAMPLE_MARKER = 15'h55E7;

    localparam int CNT_MSB  = 31;
    localparam int CNT_LSB  = 16;
    localparam int MARK_MSB = 15;
    localparam int MARK_LSB = 1;
    localparam int BIT_POS  = 0;
    localparam int ENTRY_W  = 40;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b001,
        S_SELECT  = 3'b010,
        S_CAPTURE = 3'b100
    } state_t;

    function automatic logic marker_ok(input logic [31:0] w);
        return w[MARK_MSB:MARK_LSB] == SAMPLE_MARKER;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible whenever non-empty.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = count == CNT_W'(DEPTH);
    assign empty    = count == '0;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sample_scheduler.sv
// Round-robin poller of the shared sample bus; queues fresh words per channel.
// Stale words (counter unchanged since last capture) are dropped.
module sample_scheduler
    import sample_sched_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    output logic                    output_sample,
    output logic [7:0]              channel_select,
    input  logic [31:0]             sample_data,
    output logic                    out_valid,
    output logic [ENTRY_W-1:0]      out_data,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        fifo_count,
    output logic                    overflow,
    output logic                    bus_error,
    input  logic                    clear_flags
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    state_t                  state;
    logic [NUM_CHANNELS-1:0] active_mask;
    logic [NUM_CHANNELS-1:0] seen;
    logic [15:0]             last_cnt [NUM_CHANNELS];
    logic [CH_W-1:0]         idx;
    logic [7:0]              first_ch;
    logic [7:0]              next_ch;
    logic                    next_found;
    logic [15:0]             word_cnt;
    logic                    capturing;
    logic                    bad_marker;
    logic                    fresh;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;
    logic                    drop;

    assign idx        = channel_select[CH_W-1:0];
    assign word_cnt   = sample_data[CNT_MSB:CNT_LSB];
    assign capturing  = state == S_CAPTURE;
    assign bad_marker = !marker_ok(sample_data);
    assign fresh      = !seen[idx] || last_cnt[idx] != word_cnt;
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign push       = capturing && !bad_marker && fresh && (!full || pop);
    assign drop       = capturing && !bad_marker && fresh && full && !pop;

    // Descending scan leaves the lowest qualifying index in each result.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (channel_mask[i]) first_ch = 8'(i);
            if (active_mask[i] && i > int'(channel_select)) begin
                next_ch    = 8'(i);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            output_sample  <= 1'b0;
            channel_select <= '0;
            active_mask    <= '0;
            seen           <= '0;
            overflow       <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (enable && |channel_mask) begin
                        active_mask    <= channel_mask;
                        channel_select <= first_ch;
                        output_sample  <= 1'b1;
                        state          <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    output_sample <= 1'b0;
                    state         <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (next_found) begin
                        channel_select <= next_ch;
                        output_sample  <= 1'b1;
                        state          <= S_SELECT;
                    end else if (|channel_mask) begin
                        active_mask    <= channel_mask;
                        channel_select <= first_ch;
                        output_sample  <= 1'b1;
                        state          <= S_SELECT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (push) seen[idx] <= 1'b1;
            if (clear_flags) begin
                overflow  <= 1'b0;
                bus_error <= 1'b0;
            end
            if (capturing && bad_marker) bus_error <= 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) last_cnt[idx] <= word_cnt;
    end

    sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({channel_select, sample_data}),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

endmodule
